// File: rtl/lifo_stack_param_if.sv
// Handshake/data bundle for lifo_stack_param. The master drives the strobes
// and push data; the slave (the stack) returns popped data and status.
interface lifo_stack_param_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             EN;
   logic             Push;
   logic             Pop;
   logic             Clear;
   logic [WIDTH-1:0] dataIn;
   logic [WIDTH-1:0] dataOut;
   logic             OutValid;
   logic             EMPTY;
   logic             FULL;
   logic             AlmostFull;
   logic [CW-1:0]    Count;
   logic             Overflow;
   logic             Underflow;

   // Strobes are sampled on the rising clock edge. OutValid pulses for one
   // cycle when dataOut was loaded by a successful pop; there is no backpressure.
   modport master (
      output EN, Push, Pop, Clear, dataIn,
      input  dataOut, OutValid, EMPTY, FULL, AlmostFull, Count, Overflow, Underflow
   );

   modport slave (
      input  EN, Push, Pop, Clear, dataIn,
      output dataOut, OutValid, EMPTY, FULL, AlmostFull, Count, Overflow, Underflow
   );
endinterface

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with push/pop/replace, occupancy count, almost-full
// threshold, sticky overflow/underflow flags and synchronous clear.
module lifo_stack_param #(
   parameter int WIDTH       = 4,
   parameter int DEPTH       = 8,
   parameter int AFULL_LEVEL = DEPTH - 2
) (
   input  logic                Clk,
   input  logic                Rst,
   lifo_stack_param_if.slave   bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             empty, full;
   logic             wr_en;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    top_idx;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   // Guarded so an empty stack never forms an out-of-range read index.
   assign top_idx = empty ? '0 : AW'(count_q - CW'(1));

   always_comb begin
      count_d = count_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      wr_en   = 1'b0;
      wr_idx  = AW'(count_q);
      if (!bus.EN) begin
         count_d = count_q;
      end else if (bus.Clear) begin
         count_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else begin
         unique case ({bus.Push, bus.Pop})
            2'b10: begin
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_en   = 1'b1;
                  count_d = count_q + CW'(1);
               end
            end
            2'b01: begin
               if (empty) begin
                  unf_d = 1'b1;
               end else begin
                  dout_d  = mem_q[top_idx];
                  valid_d = 1'b1;
                  count_d = count_q - CW'(1);
               end
            end
            2'b11: begin
               wr_en = 1'b1;
               if (empty) begin
                  // Push lands in slot 0; the pop half has nothing to return.
                  count_d = CW'(1);
                  unf_d   = 1'b1;
               end else begin
                  wr_idx  = top_idx;
                  dout_d  = mem_q[top_idx];
                  valid_d = 1'b1;
               end
            end
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         count_q <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Storage has no reset; writes are blocked while reset is held.
   always_ff @(posedge Clk) begin
      if (Rst && wr_en) begin
         mem_q[wr_idx] <= bus.dataIn;
      end
   end

   assign bus.dataOut    = dout_q;
   assign bus.OutValid   = valid_q;
   assign bus.Count      = count_q;
   assign bus.EMPTY      = empty;
   assign bus.FULL       = full;
   assign bus.AlmostFull = (count_q >= CW'(AFULL_LEVEL));
   assign bus.Overflow   = ovf_q;
   assign bus.Underflow  = unf_q;
endmodule

// File: tb/tb_lifo_stack_param.sv
// Bench for lifo_stack_param: directed vector table, random traffic against a
// queue-based reference, and a DEPTH=5 saturation run.
module tb_lifo_stack_param;
   localparam int W  = 4;
   localparam int D8 = 8;
   localparam int D5 = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   lifo_stack_param_if #(.WIDTH(W), .DEPTH(D8)) bus8 ();
   lifo_stack_param_if #(.WIDTH(W), .DEPTH(D5)) bus5 ();

   lifo_stack_param #(.WIDTH(W), .DEPTH(D8), .AFULL_LEVEL(D8 - 2)) dut8 (
      .Clk(clk), .Rst(rst_n), .bus(bus8)
   );
   lifo_stack_param #(.WIDTH(W), .DEPTH(D5), .AFULL_LEVEL(D5 - 2)) dut5 (
      .Clk(clk), .Rst(rst_n), .bus(bus5)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Reference state for dut8
   logic [W-1:0] mq[$];
   logic [W-1:0] m_dout;
   logic         m_valid, m_ovf, m_unf;

   typedef struct {
      bit           en, clr, push, pop;
      logic [W-1:0] din;
      int           cnt;
      logic [W-1:0] dout;
      bit           valid, ovf, unf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   task automatic model_step(input bit en, input bit clr, input bit push, input bit pop,
                             input logic [W-1:0] din);
      m_valid = 1'b0;
      if (!en) return;
      if (clr) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         return;
      end
      if (push && pop) begin
         if (mq.size() == 0) begin
            mq.push_back(din);
            m_unf = 1'b1;
         end else begin
            m_dout  = mq[mq.size()-1];
            m_valid = 1'b1;
            mq[mq.size()-1] = din;
         end
      end else if (push) begin
         if (mq.size() == D8) m_ovf = 1'b1;
         else mq.push_back(din);
      end else if (pop) begin
         if (mq.size() == 0) m_unf = 1'b1;
         else begin
            m_dout  = mq.pop_back();
            m_valid = 1'b1;
         end
      end
   endtask

   task automatic drive8(input bit en, input bit clr, input bit push, input bit pop,
                         input logic [W-1:0] din);
      bus8.EN = en; bus8.Clear = clr; bus8.Push = push; bus8.Pop = pop; bus8.dataIn = din;
      @(posedge clk);
      #1;
      model_step(en, clr, push, pop, din);
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".Count"},      32'(bus8.Count),      32'(mq.size()));
      chk({tag, ".dataOut"},    32'(bus8.dataOut),    32'(m_dout));
      chk({tag, ".OutValid"},   32'(bus8.OutValid),   32'(m_valid));
      chk({tag, ".EMPTY"},      32'(bus8.EMPTY),      32'(mq.size() == 0));
      chk({tag, ".FULL"},       32'(bus8.FULL),       32'(mq.size() == D8));
      chk({tag, ".AlmostFull"}, 32'(bus8.AlmostFull), 32'(mq.size() >= D8 - 2));
      chk({tag, ".Overflow"},   32'(bus8.Overflow),   32'(m_ovf));
      chk({tag, ".Underflow"},  32'(bus8.Underflow),  32'(m_unf));
   endtask

   task automatic add(input bit en, input bit clr, input bit push, input bit pop,
                      input logic [W-1:0] din, input int cnt, input logic [W-1:0] dout,
                      input bit valid, input bit ovf, input bit unf);
      vec_t v;
      v.en = en; v.clr = clr; v.push = push; v.pop = pop; v.din = din;
      v.cnt = cnt; v.dout = dout; v.valid = valid; v.ovf = ovf; v.unf = unf;
      vecs.push_back(v);
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      rst_n = 1'b1;
      bus8.EN = 1'b1; bus8.Clear = 1'b0; bus8.Push = 1'b1; bus8.Pop = 1'b0; bus8.dataIn = 4'h9;
      bus5.EN = 1'b0; bus5.Clear = 1'b0; bus5.Push = 1'b0; bus5.Pop = 1'b0; bus5.dataIn = '0;

      // Reset held two cycles with a push request active
      do_reset(2);
      chk("rst.Count",     32'(bus8.Count),     0);
      chk("rst.EMPTY",     32'(bus8.EMPTY),     1);
      chk("rst.FULL",      32'(bus8.FULL),      0);
      chk("rst.dataOut",   32'(bus8.dataOut),   0);
      chk("rst.OutValid",  32'(bus8.OutValid),  0);
      chk("rst.Overflow",  32'(bus8.Overflow),  0);
      chk("rst.Underflow", 32'(bus8.Underflow), 0);
      drive8(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      chk("rst.after_release.Count", 32'(bus8.Count), 0);

      // Directed table: LIFO order, underflow, empty push+pop, fill, replace, EN, Clear
      add(1,0,1,0,4'h2, 1,4'h0,0,0,0);
      add(1,0,1,0,4'h4, 2,4'h0,0,0,0);
      add(1,0,1,0,4'h6, 3,4'h0,0,0,0);
      add(1,0,0,1,4'h0, 2,4'h6,1,0,0);
      add(1,0,0,1,4'h0, 1,4'h4,1,0,0);
      add(1,0,0,1,4'h0, 0,4'h2,1,0,0);
      add(1,0,0,1,4'h0, 0,4'h2,0,0,1);
      add(1,0,1,1,4'h3, 1,4'h2,0,0,1);
      add(1,0,0,1,4'h0, 0,4'h3,1,0,1);
      add(1,1,0,0,4'h0, 0,4'h3,0,0,0);
      for (int i = 1; i <= 8; i++) add(1,0,1,0,4'(i), i,4'h3,0,0,0);
      add(1,0,1,0,4'hF, 8,4'h3,0,1,0);
      add(1,0,1,1,4'hA, 8,4'h8,1,1,0);
      add(1,0,0,1,4'h0, 7,4'hA,1,1,0);
      add(1,0,0,1,4'h0, 6,4'h7,1,1,0);
      add(0,0,1,0,4'h5, 6,4'h7,0,1,0);
      add(1,0,0,1,4'h0, 5,4'h6,1,1,0);
      add(1,0,0,1,4'h0, 4,4'h5,1,1,0);
      add(1,0,0,1,4'h0, 3,4'h4,1,1,0);
      add(1,1,1,0,4'hC, 0,4'h4,0,0,0);

      foreach (vecs[k]) begin
         string tag;
         tag = $sformatf("vec%0d", k);
         drive8(vecs[k].en, vecs[k].clr, vecs[k].push, vecs[k].pop, vecs[k].din);
         chk({tag, ".Count"},      32'(bus8.Count),      32'(vecs[k].cnt));
         chk({tag, ".dataOut"},    32'(bus8.dataOut),    32'(vecs[k].dout));
         chk({tag, ".OutValid"},   32'(bus8.OutValid),   32'(vecs[k].valid));
         chk({tag, ".Overflow"},   32'(bus8.Overflow),   32'(vecs[k].ovf));
         chk({tag, ".Underflow"},  32'(bus8.Underflow),  32'(vecs[k].unf));
         chk({tag, ".EMPTY"},      32'(bus8.EMPTY),      32'(vecs[k].cnt == 0));
         chk({tag, ".FULL"},       32'(bus8.FULL),       32'(vecs[k].cnt == D8));
         chk({tag, ".AlmostFull"}, 32'(bus8.AlmostFull), 32'(vecs[k].cnt >= 6));
      end

      // Random traffic, biased toward filling or draining in phases
      for (int n = 0; n < 400; n++) begin
         bit en, clr, push, pop;
         int bias;
         bias = ((n / 50) % 2 == 0) ? 75 : 25;
         en   = ($urandom_range(0, 9) != 0);
         clr  = ($urandom_range(0, 59) == 0);
         push = ($urandom_range(0, 99) < bias);
         pop  = ($urandom_range(0, 99) >= bias) || ($urandom_range(0, 4) == 0);
         drive8(en, clr, push, pop, 4'($urandom));
         check_model($sformatf("rnd%0d", n));
      end

      // Reset in the middle of activity overrides EN/Push
      drive8(1'b1, 1'b0, 1'b1, 1'b0, 4'h1);
      drive8(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
      bus8.EN = 1'b1; bus8.Push = 1'b1; bus8.Pop = 1'b1; bus8.Clear = 1'b0;
      do_reset(1);
      check_model("midrst");

      // DEPTH=5 instance: saturates at 5, no wrap, then drains in LIFO order
      bus8.EN = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         bus5.EN = 1'b1; bus5.Push = 1'b1; bus5.Pop = 1'b0; bus5.dataIn = 4'(i);
         @(posedge clk);
         #1;
         chk($sformatf("d5.push%0d.Count", i),    32'(bus5.Count),    32'((i < D5) ? i : D5));
         chk($sformatf("d5.push%0d.FULL", i),     32'(bus5.FULL),     32'(i >= D5));
         chk($sformatf("d5.push%0d.Overflow", i), 32'(bus5.Overflow), 32'(i > D5));
      end
      for (int i = D5; i >= 1; i--) begin
         bus5.Push = 1'b0; bus5.Pop = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("d5.pop%0d.dataOut", i),  32'(bus5.dataOut),  32'(i));
         chk($sformatf("d5.pop%0d.OutValid", i), 32'(bus5.OutValid), 1);
         chk($sformatf("d5.pop%0d.Count", i),    32'(bus5.Count),    32'(i - 1));
      end
      chk("d5.EMPTY", 32'(bus5.EMPTY), 1);
      bus5.EN = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
